exec_controller: RTL and testbench

- Run/step/halt sequencer for the 8-bit CPU datapath.
- Turns raw board push-buttons into a single-cycle execution enable (cpu_en) that the datapath uses to gate PC/register updates.
- Supports free-run at a divided rate, single-step, PC breakpoint and HALT-opcode detection.
- Sits between the board top (buttons, 7-segment display) and the datapath/instruction-ROM pair.

---
 rtl/exec_controller.sv | 132 +++++++++++++
 tb/tb_exec_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
// exec_controller: run/step/halt sequencer producing a single-cycle cpu_en for the datapath.
// Buttons are synchronized and debounced; RUN paces execution and stops on a breakpoint or HALT opcode.
module exec_controller #(
    parameter int         DB_COUNT    = 500000,
    parameter int         RATE_DIV    = 25000000,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_btn,
    input  logic        step_btn,
    input  logic        halt_btn,
    input  logic [7:0]  pc,
    input  logic [7:0]  instruction,
    input  logic [7:0]  bp_addr,
    input  logic        bp_en,
    output logic        cpu_en,
    output logic        running,
    output logic        halted,
    output logic        bp_hit,
    output logic [15:0] instr_count
);
    localparam int DBW = $clog2(DB_COUNT + 1);
    localparam int RW  = $clog2(RATE_DIV + 1);

    typedef enum logic [1:0] {IDLE, STEP, RUN, HALTED} state_t;

    logic [2:0]     raw, sync1_q, sync2_q, db_q, db_d, press_q;
    logic [DBW-1:0] cnt_q [3];
    logic [DBW-1:0] cnt_d [3];
    logic           halt_p, step_p, run_p;
    state_t         state_q, state_d;
    logic [RW-1:0]  rate_q, rate_d;
    logic           skip_q, skip_d, bp_hit_d, tick, is_halt;

    assign raw = {halt_btn, step_btn, run_btn};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
                if (cnt_q[i] == DBW'(DB_COUNT - 1)) begin
                    cnt_d[i] = '0;
                    db_d[i]  = sync2_q[i];
                end
            end
        end
    end

    // halt > step > run when press pulses coincide
    assign halt_p  = press_q[2];
    assign step_p  = press_q[1] & ~press_q[2];
    assign run_p   = press_q[0] & ~|press_q[2:1];
    assign tick    = rate_q == RW'(RATE_DIV - 1);
    assign is_halt = instruction == HALT_OPCODE;

    always_comb begin
        state_d  = state_q;
        rate_d   = rate_q;
        skip_d   = skip_q;
        bp_hit_d = bp_hit;
        cpu_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (step_p) begin
                    state_d = is_halt ? HALTED : STEP;
                end else if (run_p) begin
                    state_d = is_halt ? HALTED : RUN;
                    if (!is_halt) begin
                        rate_d   = '0;
                        skip_d   = 1'b1;
                        bp_hit_d = 1'b0;
                    end
                end
            end
            STEP: begin
                cpu_en  = 1'b1;
                state_d = IDLE;
            end
            RUN: begin
                rate_d = tick ? '0 : rate_q + 1'b1;
                if (halt_p) begin
                    state_d = IDLE;
                    rate_d  = '0;
                end else if (tick) begin
                    if (is_halt) begin
                        state_d = HALTED;
                    end else if (bp_en && pc == bp_addr && !skip_q) begin
                        state_d  = IDLE;
                        bp_hit_d = 1'b1;
                    end else begin
                        cpu_en = 1'b1;
                        skip_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            press_q     <= '0;
            cnt_q       <= '{default: '0};
            state_q     <= IDLE;
            rate_q      <= '0;
            skip_q      <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
            bp_hit      <= 1'b0;
            instr_count <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            press_q     <= db_d & ~db_q;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            rate_q      <= rate_d;
            skip_q      <= skip_d;
            running     <= state_d == RUN;
            halted      <= state_d == HALTED;
            bp_hit      <= bp_hit_d;
            instr_count <= instr_count + 16'(cpu_en && instr_count != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: randomized programs/breakpoints against an event-level model of run/step/halt.
module tb_exec_controller;
    logic clk = 0, reset = 1;
    logic run_btn = 0, step_btn = 0, halt_btn = 0, bp_en = 0;
    logic [7:0] bp_addr = 0, pc = 0, pc_ld_val = 0, instruction;
    logic pc_ld = 0;
    logic cpu_en, running, halted, bp_hit;
    logic [15:0] instr_count;
    logic run2 = 0, halt2 = 0;
    logic cpu_en2, running2, halted2, bp_hit2;
    logic [15:0] cnt2;
    logic [7:0] rom [256];

    int n_cmp = 0, n_bad = 0, ce_total = 0, cyc = 0, run_last = -1;
    int exp_count = 0;
    bit exp_halted = 0, exp_bp = 0, prev_ce = 0;

    always #5 clk = ~clk;

    exec_controller #(.DB_COUNT(4), .RATE_DIV(3), .HALT_OPCODE(8'hFF)) dut (
        .clk(clk), .reset(reset), .run_btn(run_btn), .step_btn(step_btn), .halt_btn(halt_btn),
        .pc(pc), .instruction(instruction), .bp_addr(bp_addr), .bp_en(bp_en),
        .cpu_en(cpu_en), .running(running), .halted(halted), .bp_hit(bp_hit), .instr_count(instr_count)
    );

    exec_controller #(.DB_COUNT(4), .RATE_DIV(1), .HALT_OPCODE(8'hFF)) dut2 (
        .clk(clk), .reset(reset), .run_btn(run2), .step_btn(1'b0), .halt_btn(halt2),
        .pc(8'h00), .instruction(8'h00), .bp_addr(8'h00), .bp_en(1'b0),
        .cpu_en(cpu_en2), .running(running2), .halted(halted2), .bp_hit(bp_hit2), .instr_count(cnt2)
    );

    assign instruction = rom[pc];

    // datapath stand-in: PC advances on every executed instruction
    always @(posedge clk) begin
        if (pc_ld) pc <= pc_ld_val;
        else if (cpu_en) pc <= pc + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (cpu_en) begin
            ce_total++;
            check("ce_b2b", prev_ce, 0);
            if (running && run_last >= 0) check("run_gap", cyc - run_last, 3);
        end
        run_last = (cpu_en && running) ? cyc : (running ? run_last : -1);
        prev_ce = cpu_en;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] m);
        {halt_btn, step_btn, run_btn} = m;
        tick(12);
        {halt_btn, step_btn, run_btn} = 3'b000;
        tick(12);
    endtask

    task automatic do_reset();
        reset = 1;
        tick(2);
        reset = 0;
        exp_count = 0;
        exp_halted = 0;
        exp_bp = 0;
    endtask

    task automatic load_pc(input logic [7:0] v);
        pc_ld_val = v;
        pc_ld = 1;
        tick(1);
        pc_ld = 0;
    endtask

    task automatic model_run(output int n);
        logic [7:0] p = pc;
        bit skip = 1;
        n = 0;
        if (exp_halted) return;
        if (rom[p] == 8'hFF) begin
            exp_halted = 1;
            return;
        end
        exp_bp = 0;
        for (int g = 0; g < 300; g++) begin
            if (rom[p] == 8'hFF) begin
                exp_halted = 1;
                break;
            end
            if (bp_en && p == bp_addr && !skip) begin
                exp_bp = 1;
                break;
            end
            n++;
            p++;
            skip = 0;
        end
    endtask

    task automatic settle_check(input string tag, input int c0, input logic [7:0] p0, input int n);
        check({tag, "_ce"}, ce_total - c0, n);
        check({tag, "_pc"}, pc, p0 + 8'(n));
        check({tag, "_halted"}, halted, exp_halted);
        check({tag, "_running"}, running, 0);
        check({tag, "_bp"}, bp_hit, exp_bp);
        exp_count += n;
        check({tag, "_count"}, instr_count, exp_count);
    endtask

    task automatic run_check(input string tag);
        int n, k = 0, c0 = ce_total;
        logic [7:0] p0 = pc;
        model_run(n);
        press(3'b001);
        while (running && k < 1000) begin
            tick(1);
            k++;
        end
        tick(4);
        settle_check(tag, c0, p0, n);
    endtask

    task automatic step_check(input string tag);
        int n, c0 = ce_total;
        logic [7:0] p0 = pc;
        n = (exp_halted || rom[pc] == 8'hFF) ? 0 : 1;
        if (rom[pc] == 8'hFF) exp_halted = 1;
        press(3'b010);
        tick(2);
        settle_check(tag, c0, p0, n);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, c0, c1;
        logic [7:0] p0, j;
        for (int i = 0; i < 256; i++) rom[i] = 8'h12;
        tick(3);
        do_reset();
        load_pc(8'h00);
        tick(100);
        check("idle_ce", ce_total, 0);
        check("idle_count", instr_count, 0);
        check("idle_running", running, 0);
        check("idle_halted", halted, 0);
        check("idle_bp", bp_hit, 0);

        // clean step held 20 cycles
        c0 = ce_total;
        step_btn = 1;
        k = 0;
        while (!cpu_en && k < 30) begin
            tick(1);
            k++;
        end
        check("step_latency_ok", k >= 6 && k <= 8, 1);
        tick(k < 20 ? 20 - k : 0);
        step_btn = 0;
        tick(12);
        check("step_ce", ce_total - c0, 1);
        check("step_count", instr_count, 1);
        check("step_running", running, 0);
        exp_count = 1;

        // bouncing step, then stable
        c0 = ce_total;
        for (int i = 0; i < 5; i++) begin
            step_btn = ~step_btn;
            tick(2);
        end
        tick(15);
        step_btn = 0;
        tick(12);
        check("bounce_ce", ce_total - c0, 1);
        check("bounce_count", instr_count, 2);
        exp_count = 2;

        // halt press in IDLE does nothing
        c0 = ce_total;
        press(3'b100);
        check("idle_halt_ce", ce_total - c0, 0);
        check("idle_halt_halted", halted, 0);

        // breakpoint at 5, then resume past it into a HALT at 9
        do_reset();
        for (int i = 0; i < 21; i++) rom[i] = 8'h10 + 8'(i);
        rom[9] = 8'hFF;
        load_pc(8'h00);
        bp_en = 1;
        bp_addr = 8'h05;
        run_check("bp_first");
        run_check("bp_resume");
        run_check("halted_run");
        step_check("halted_step");
        do_reset();
        check("reset_halted", halted, 0);
        check("reset_count", instr_count, 0);

        // asynchronous reset while RUN is issuing an enable
        for (int i = 0; i < 256; i++) rom[i] = 8'h20;
        bp_en = 0;
        load_pc(8'h00);
        run_btn = 1;
        k = 0;
        while (!cpu_en && k < 50) begin
            tick(1);
            k++;
        end
        check("arst_saw_ce", cpu_en, 1);
        #1 reset = 1;
        #1;
        check("arst_ce", cpu_en, 0);
        check("arst_running", running, 0);
        check("arst_count", instr_count, 0);
        tick(1);
        reset = 0;
        run_btn = 0;
        exp_count = 0;
        tick(12);

        // halt and step together in RUN
        load_pc(8'h00);
        press(3'b001);
        check("hs_running", running, 1);
        tick(7);
        halt_btn = 1;
        step_btn = 1;
        k = 0;
        while (running && k < 40) begin
            tick(1);
            k++;
        end
        c1 = ce_total;
        check("hs_stopped", running, 0);
        tick(25);
        halt_btn = 0;
        step_btn = 0;
        tick(12);
        check("hs_ce_after", ce_total - c1, 0);
        check("hs_count", instr_count, pc);
        check("hs_halted", halted, 0);

        // randomized programs
        for (int s = 0; s < 12; s++) begin
            do_reset();
            for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 254));
            p0 = 8'($urandom);
            load_pc(p0);
            j = 8'($urandom_range(8, 20));
            rom[p0 + j] = 8'hFF;
            if ($urandom_range(0, 3) == 0) rom[p0 + 8'($urandom_range(0, 3))] = 8'hFF;
            bp_en = 1'($urandom);
            bp_addr = p0 + 8'($urandom_range(0, 15));
            for (int t = $urandom_range(0, 2); t > 0; t--) step_check($sformatf("r%0d_step", s));
            for (int r = 0; r < 3; r++) run_check($sformatf("r%0d_run%0d", s, r));
            check($sformatf("r%0d_final_halted", s), halted, 1);
        end

        // saturation using a free-running instance (one enable per cycle)
        do_reset();
        run2 = 1;
        tick(12);
        run2 = 0;
        tick(65388);
        check("sat_pre", cnt2 > 16'd65300 && cnt2 < 16'hFFFF, 1);
        tick(200);
        check("sat_full", cnt2, 16'hFFFF);
        check("sat_running", running2, 1);
        tick(20);
        check("sat_hold", cnt2, 16'hFFFF);
        halt2 = 1;
        tick(12);
        halt2 = 0;
        tick(12);
        check("sat_halt_running", running2, 0);
        check("sat_halt_count", cnt2, 16'hFFFF);
        check("sat_halted", halted2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
